// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - two-requester round-robin front end sharing one 4-bit divider
// Optional DIV_ZERO_FLAG_EN: divisor 0 forces Q=F, R=dividend and raises rsp_div_by_zero.

module divider_4bit (
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic [3:0] quotient,
    output logic [3:0] remainder
);
    logic [4:0] rem_v;
    logic [3:0] quo_v;

    // Restoring division; a zero divisor naturally yields Q=F and R=dividend.
    always_comb begin
        rem_v = 5'd0;
        quo_v = 4'd0;
        for (int i = 3; i >= 0; i--) begin
            rem_v = {rem_v[3:0], dividend[i]};
            if (rem_v >= {1'b0, divisor}) begin
                rem_v    = rem_v - {1'b0, divisor};
                quo_v[i] = 1'b1;
            end
        end
        quotient  = quo_v;
        remainder = rem_v[3:0];
    end
endmodule

module div_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_dividend,
    input  logic [3:0] req0_divisor,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_dividend,
    input  logic [3:0] req1_divisor,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_quotient,
    output logic [3:0] rsp_remainder,
    output logic       rsp_div_by_zero
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic       id_q, id_d;
    logic [3:0] a_q, a_d, b_q, b_d;
    logic [3:0] quo_q, quo_d, rem_q, rem_d;
    logic       dz_q, dz_d;
    logic [3:0] div_quo, div_rem, res_quo, res_rem;
    logic       res_dz, grant0, grant1;

    divider_4bit u_div (
        .dividend  (a_q),
        .divisor   (b_q),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

`ifdef DIV_ZERO_FLAG_EN
    assign res_dz  = (b_q == 4'd0);
    assign res_quo = res_dz ? 4'hF : div_quo;
    assign res_rem = res_dz ? a_q  : div_rem;
`else
    assign res_dz  = 1'b0;
    assign res_quo = div_quo;
    assign res_rem = div_rem;
`endif

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        // Under contention the requester not served last wins.
        grant0 = req0_valid && (!req1_valid || last_q);
        grant1 = req1_valid && (!req0_valid || !last_q);
        case (state_q)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0) begin
                    a_d     = req0_dividend;
                    b_d     = req0_divisor;
                    id_d    = 1'b0;
                    last_d  = 1'b0;
                    state_d = CALC;
                end else if (grant1) begin
                    a_d     = req1_dividend;
                    b_d     = req1_divisor;
                    id_d    = 1'b1;
                    last_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                quo_d   = res_quo;
                rem_d   = res_rem;
                dz_d    = res_dz;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            quo_q   <= 4'd0;
            rem_q   <= 4'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign rsp_valid       = (state_q == RESP);
    assign rsp_id          = id_q;
    assign rsp_quotient    = quo_q;
    assign rsp_remainder   = rem_q;
    assign rsp_div_by_zero = dz_q;
endmodule
